// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate BIST sequencer: op encodings, FSM states and golden model.
package gate_bist_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_LAST = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Only the low n bits of vec take part in the reduction.
  function automatic logic expected_y(input logic [2:0] op, input logic [7:0] vec, input int n);
    logic a;
    logic o;
    logic x;
    logic y;
    a = 1'b1;
    o = 1'b0;
    x = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        a = a & vec[i];
        o = o | vec[i];
        x = x ^ vec[i];
      end
    end
    case (op)
      OP_AND:  y = a;
      OP_OR:   y = o;
      OP_NAND: y = ~a;
      OP_NOR:  y = ~o;
      OP_XOR:  y = x;
      OP_XNOR: y = ~x;
      default: y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// Stimulus, sample and result signals between the BIST controller and its environment.
interface gate_bist_ctrl_if #(parameter int N_IN = 2);
  logic            start;
  logic [2:0]      op;
  logic [N_IN-1:0] dut_in;
  logic            dut_y;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic [N_IN-1:0] first_fail;

  modport master (
    output start, op, dut_y,
    input  dut_in, busy, done, pass, err_cnt, first_fail
  );

  modport slave (
    input  start, op, dut_y,
    output dut_in, busy, done, pass, err_cnt, first_fail
  );
endinterface

// File: rtl/gate_ref_model.sv
// Combinational golden model of the basic N-input gate family; reusable by gate testbenches.
module gate_ref_model
  import gate_bist_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [2:0]      op,
  input  logic [N_IN-1:0] vec,
  output logic            exp_y
);

  assign exp_y = expected_y(op, 8'(vec), N_IN);

endmodule

// File: rtl/gate_bist_ctrl.sv
// Exhaustive-sweep BIST sequencer for an N-input gate; done 2^N_IN*(SETTLE+1)+1 cycles after start.
// GATE_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  gate_bist_ctrl_if.slave bus
);

  localparam int CW = $clog2(SETTLE + 1);

  state_t          state, state_n;
  logic [N_IN-1:0] vec, vec_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      op_q, op_q_n;
  logic [N_IN:0]   err, err_n;
  logic [N_IN-1:0] ff, ff_n;
  logic            pass_q, pass_n;
  logic            exp_y;
  logic            mismatch;
  logic            stop_now;

  gate_ref_model #(.N_IN(N_IN)) u_ref (
    .op    (op_q),
    .vec   (vec),
    .exp_y (exp_y)
  );

  assign mismatch = (bus.dut_y != exp_y);

`ifdef GATE_BIST_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      vec    <= '0;
      cnt    <= '0;
      op_q   <= '0;
      err    <= '0;
      ff     <= '0;
      pass_q <= 1'b0;
    end else begin
      state  <= state_n;
      vec    <= vec_n;
      cnt    <= cnt_n;
      op_q   <= op_q_n;
      err    <= err_n;
      ff     <= ff_n;
      pass_q <= pass_n;
    end
  end

  always_comb begin
    state_n = state;
    vec_n   = vec;
    cnt_n   = cnt;
    op_q_n  = op_q;
    err_n   = err;
    ff_n    = ff;
    pass_n  = pass_q;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          op_q_n = bus.op;
          vec_n  = '0;
          cnt_n  = '0;
          err_n  = '0;
          ff_n   = '0;
          pass_n = 1'b0;
          state_n = (bus.op <= OP_LAST) ? ST_SETTLE : ST_DONE;
        end
      end
      ST_SETTLE: begin
        if (cnt == CW'(SETTLE - 1)) begin
          cnt_n   = '0;
          state_n = ST_CHECK;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          err_n = err + (N_IN+1)'(1);
          if (err == '0) ff_n = vec;
        end
        // pass is settled on the way into DONE so it is valid alongside done.
        if ((&vec) || stop_now) begin
          pass_n  = !mismatch && (err == '0);
          state_n = ST_DONE;
        end else begin
          vec_n   = vec + N_IN'(1);
          state_n = ST_SETTLE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.busy       = (state == ST_SETTLE) || (state == ST_CHECK);
  assign bus.done       = (state == ST_DONE);
  assign bus.dut_in     = bus.busy ? vec : '0;
  assign bus.pass       = pass_q;
  assign bus.err_cnt    = err;
  assign bus.first_fail = ff;

endmodule
